// File: rtl/combo_lock_state_machine.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : combo_lock_state_machine                                     |
// | Description : Edge-triggered 16-bit combination lock with error counting   |
// |               and ALARM lockout. Define COMBO_PIN_PROGRAM_EN to allow the  |
// |               pin to be reprogrammed by a trig edge while UNLOCKED.        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module combo_lock_state_machine #(
    parameter logic [15:0] DEFAULT_PIN = 16'hBABA,
    parameter int          MAX_ERR     = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] pinCode,
    input  logic        trig,
    input  logic        lock,
    output logic [1:0]  state,
    output logic [1:0]  errCount
);

    typedef enum logic [1:0] {
        ST_LOCKED   = 2'b00,
        ST_UNLOCKED = 2'b01,
        ST_ALARM    = 2'b10,
        ST_ILLEGAL  = 2'b11
    } state_t;

    localparam logic [2:0] C_MAX_ERR_W3 = 3'(MAX_ERR);
    localparam logic [1:0] C_MAX_ERR_W2 = 2'(MAX_ERR);

    state_t      r_state;
    logic [1:0]  r_err;
    logic        r_trig_q;
    logic        r_lock_q;
    logic        w_trig_rise;
    logic        w_lock_rise;
    logic [15:0] w_pin;
    logic [2:0]  w_err_inc;

`ifdef COMBO_PIN_PROGRAM_EN
    logic [15:0] r_pin;
    assign w_pin = r_pin;
`else
    assign w_pin = DEFAULT_PIN;
`endif

    assign w_trig_rise = trig & ~r_trig_q;
    assign w_lock_rise = lock & ~r_lock_q;
    assign w_err_inc   = {1'b0, r_err} + 3'd1;

    always_ff @(posedge clk) begin
        // Edge detectors track the inputs even in reset so a held level is not an event.
        r_trig_q <= trig;
        r_lock_q <= lock;
        if (rst) begin
            r_state <= ST_LOCKED;
            r_err   <= 2'd0;
`ifdef COMBO_PIN_PROGRAM_EN
            r_pin   <= DEFAULT_PIN;
`endif
        end else begin
            case (r_state)
                ST_LOCKED: begin
                    if (w_trig_rise) begin
                        if (pinCode == w_pin) begin
                            r_state <= ST_UNLOCKED;
                            r_err   <= 2'd0;
                        end else if (w_err_inc >= C_MAX_ERR_W3) begin
                            r_state <= ST_ALARM;
                            r_err   <= C_MAX_ERR_W2;
                        end else begin
                            r_err   <= w_err_inc[1:0];
                        end
                    end
                end
                ST_UNLOCKED: begin
                    if (w_lock_rise) begin
                        r_state <= ST_LOCKED;
                        r_err   <= 2'd0;
                    end
`ifdef COMBO_PIN_PROGRAM_EN
                    else if (w_trig_rise) begin
                        r_pin   <= pinCode;
                    end
`endif
                end
                ST_ALARM: begin
                    r_err <= C_MAX_ERR_W2;
                end
                default: begin
                    r_state <= ST_LOCKED;
                    r_err   <= 2'd0;
                end
            endcase
        end
    end

    assign state    = r_state;
    assign errCount = r_err;

endmodule
`default_nettype wire

// File: tb/tb_combo_lock_state_machine.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_combo_lock_state_machine                                  |
// | Description : Directed and random checks of the combination lock against   |
// |               an event-level behavioural model.                            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_combo_lock_state_machine;

    localparam logic [15:0] C_PIN     = 16'hBABA;
    localparam int          C_MAX_ERR = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] pinCode = 16'h0000;
    logic        trig = 1'b0;
    logic        lock = 1'b0;
    logic [1:0]  state;
    logic [1:0]  errCount;

    int n_checks = 0;
    int n_errors = 0;

    // Model: mode 0 = locked, 1 = open, 2 = alarm
    int          m_mode = 0;
    int          m_errs = 0;
    logic [15:0] m_pin  = C_PIN;
    logic        m_prev_t = 1'b0;
    logic        m_prev_l = 1'b0;

    combo_lock_state_machine #(
        .DEFAULT_PIN(C_PIN),
        .MAX_ERR    (C_MAX_ERR)
    ) u_dut (
        .clk     (clk),
        .rst     (rst),
        .pinCode (pinCode),
        .trig    (trig),
        .lock    (lock),
        .state   (state),
        .errCount(errCount)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_edge(input logic r, input logic t, input logic l, input logic [15:0] p);
        bit submit, relock;
        submit = t && !m_prev_t;
        relock = l && !m_prev_l;
        m_prev_t = t;
        m_prev_l = l;
        if (r) begin
            m_mode = 0;
            m_errs = 0;
            m_pin  = C_PIN;
        end else if (m_mode == 0 && submit) begin
            if (p == m_pin) begin
                m_mode = 1;
                m_errs = 0;
            end else begin
                m_errs = m_errs + 1;
                if (m_errs >= C_MAX_ERR) m_mode = 2;
            end
        end else if (m_mode == 1) begin
            if (relock) m_mode = 0;
`ifdef COMBO_PIN_PROGRAM_EN
            else if (submit) m_pin = p;
`endif
        end
    endfunction

    task automatic step(input logic r, input logic t, input logic l, input logic [15:0] p);
        @(negedge clk);
        rst = r; trig = t; lock = l; pinCode = p;
        @(posedge clk);
        model_edge(r, t, l, p);
        #1;
        check("state", {14'd0, state}, 16'(m_mode));
        check("errCount", {14'd0, errCount}, 16'(m_errs));
    endtask

    task automatic submit(input logic [15:0] p);
        step(1'b0, 1'b1, 1'b0, p);
        step(1'b0, 1'b0, 1'b0, p);
    endtask

    task automatic relock();
        step(1'b0, 1'b0, 1'b1, 16'h0000);
        step(1'b0, 1'b0, 1'b0, 16'h0000);
    endtask

    initial begin
        logic t_r, t_t, t_l;
        logic [15:0] t_p;

        step(1'b1, 1'b0, 1'b0, 16'h0000);
        step(1'b1, 1'b0, 1'b0, 16'h0000);
        check("reset_state", {14'd0, state}, 16'h0000);
        check("reset_err", {14'd0, errCount}, 16'h0000);
        step(1'b0, 1'b0, 1'b0, 16'h0000);

        submit(16'hABCD);
        check("wrong1_err", {14'd0, errCount}, 16'd1);
        submit(16'hBABA);
        check("open_state", {14'd0, state}, 16'd1);
        check("open_err", {14'd0, errCount}, 16'd0);

        // Simultaneous trig and lock while open: lock wins, pin untouched
        step(1'b0, 1'b1, 1'b1, 16'h1234);
        check("both_state", {14'd0, state}, 16'd0);
        step(1'b0, 1'b0, 1'b0, 16'h1234);
        submit(16'h1234);
        check("both_pin_err", {14'd0, errCount}, 16'd1);
        submit(16'hBABA);
        check("reopen_state", {14'd0, state}, 16'd1);

        submit(16'hFACE);
        relock();
        submit(16'hFACE);
`ifndef COMBO_PIN_PROGRAM_EN
        check("face_err", {14'd0, errCount}, 16'd1);
        submit(16'hBABA);
        check("default_open", {14'd0, state}, 16'd1);
`endif
        relock();

        step(1'b1, 1'b0, 1'b0, 16'h0000);
        step(1'b0, 1'b1, 1'b0, 16'hDADA);
        check("hold_first", {14'd0, errCount}, 16'd1);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 16'hDADA);
        check("hold_once", {14'd0, errCount}, 16'd1);
        step(1'b0, 1'b0, 1'b0, 16'hDADA);

        submit(16'hDADA);
        check("wrong2_err", {14'd0, errCount}, 16'd2);
        submit(16'hDADA);
        check("alarm_state", {14'd0, state}, 16'd2);
        check("alarm_err", {14'd0, errCount}, 16'd3);
        submit(16'hDADA);
        submit(16'hBABA);
        relock();
        check("alarm_sticky", {14'd0, state}, 16'd2);
        step(1'b1, 1'b0, 1'b0, 16'h0000);
        check("alarm_rst", {14'd0, state}, 16'd0);
        check("alarm_rst_err", {14'd0, errCount}, 16'd0);

        t_t = 1'b0;
        t_l = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            t_r = ($urandom_range(0, 79) == 0);
            if ($urandom_range(0, 2) == 0) t_t = ~t_t;
            if ($urandom_range(0, 4) == 0) t_l = ~t_l;
            case ($urandom_range(0, 3))
                0:       t_p = C_PIN;
                1:       t_p = m_pin;
                2:       t_p = 16'($urandom);
                default: t_p = 16'hCACA;
            endcase
            step(t_r, t_t, t_l, t_p);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/combo_lock_state_machine.md
COMBO_LOCK_STATE_MACHINE -- requirements
Module: combo_lock_state_machine

Interface
REQ-001 Parameter DEFAULT_PIN, 16'hBABA, unlock code loaded into the pin register at reset.
REQ-002 Parameter MAX_ERR, 3, number of consecutive wrong codes that forces ALARM (legal range 1..3).
REQ-003 clk  input  1  sole clock; all state changes occur on its rising edge.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 pinCode  input  16  candidate code, sampled on the cycle a trig rising edge is detected.
REQ-006 trig  input  1  level input; its 0->1 transition submits pinCode.
REQ-007 lock  input  1  level input; its 0->1 transition relocks the lock.
REQ-008 state  output  2  registered FSM state: 2'b00 LOCKED, 2'b01 UNLOCKED, 2'b10 ALARM.
REQ-009 errCount  output  2  registered count of consecutive wrong codes, saturating at MAX_ERR.

Function
REQ-010 The block SHALL register trig and lock each cycle (trig_q, lock_q); trig_rise = trig & ~trig_q; lock_rise = lock & ~lock_q.
REQ-011 A level held high for many cycles SHALL produce exactly one event; new events require a return to 0.
REQ-012 Outputs SHALL update at the same rising edge at which the rise is detected (one-cycle latency from the input transition).
REQ-013 LOCKED, trig_rise, pinCode == pin register: state -> UNLOCKED, errCount -> 0.
REQ-014 LOCKED, trig_rise, pinCode != pin register, errCount+1 < MAX_ERR: stay LOCKED, errCount increments.
REQ-015 LOCKED, trig_rise, pinCode != pin register, errCount+1 == MAX_ERR: state -> ALARM, errCount -> MAX_ERR.
REQ-016 LOCKED, lock_rise: no effect.
REQ-017 UNLOCKED, lock_rise: state -> LOCKED, errCount stays 0.
REQ-018 UNLOCKED, trig_rise without lock_rise: pin register loads pinCode (see REQ-026); state stays UNLOCKED.
REQ-019 UNLOCKED, trig_rise and lock_rise in the same cycle: lock wins, pin register unchanged, state -> LOCKED.
REQ-020 ALARM SHALL ignore trig and lock; only rst exits ALARM; errCount holds MAX_ERR.
REQ-021 Encoding 2'b11 SHALL never be produced; if reached, the next cycle goes to LOCKED with errCount 0.
REQ-022 Code comparison SHALL be a full 16-bit equality; there are no don't-care bits.

Reset
REQ-023 On rst high at a clk edge: state = LOCKED (2'b00), errCount = 0, pin register = DEFAULT_PIN.
REQ-024 During reset trig_q and lock_q SHALL load the current trig and lock values, so a level already high at reset release creates no event.
REQ-025 Reset SHALL take priority over all events at any point in operation; a reprogrammed pin is lost.

Configuration
REQ-026 Macro COMBO_PIN_PROGRAM_EN defined: REQ-018 is active and trig_rise in UNLOCKED reprograms the pin.
REQ-027 Macro COMBO_PIN_PROGRAM_EN undefined: trig in UNLOCKED is ignored; the pin register is the constant DEFAULT_PIN.

Verification
REQ-028 Reset, then submit 16'hABCD -> state 00, errCount 1; then submit 16'hBABA -> state 01, errCount 0.
REQ-029 In UNLOCKED (macro defined), submit 16'hCACA, pulse lock -> state 00; submit 16'hCACA -> state 01; submit 16'hBABA after relock -> errCount 1.
REQ-030 In LOCKED, submit 16'hDADA three times -> errCount 1, 2, then state 10 with errCount 3; a fourth submit or a correct code leaves state 10; rst -> state 00, errCount 0.
REQ-031 Hold trig high for 6 cycles with a wrong code -> errCount increments exactly once, one cycle after trig rises.
REQ-032 In UNLOCKED, raise trig and lock in the same cycle with pinCode 16'h1234 -> state 00, and 16'h1234 does not unlock.
REQ-033 With the macro undefined, submit 16'hFACE while UNLOCKED, then relock -> 16'hBABA still unlocks and 16'hFACE increments errCount.
